bcd_hex_counter: RTL

BCD_HEX_COUNTER -- requirements
Module: bcd_hex_counter

---
 rtl/seg7_pkg.sv | 53 +++++
 rtl/seg7_digit.sv | 14 +
 rtl/bcd_hex_counter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment display constants and decode helpers.
// Patterns are active-low, ordered {a, b, c, d, e, f, g} from MSB to LSB.
package seg7_pkg;

  localparam logic [6:0] SegBlank = 7'b1111111;

  localparam logic [6:0] Seg0 = 7'b0000001;
  localparam logic [6:0] Seg1 = 7'b1001111;
  localparam logic [6:0] Seg2 = 7'b0010010;
  localparam logic [6:0] Seg3 = 7'b0000110;
  localparam logic [6:0] Seg4 = 7'b1001100;
  localparam logic [6:0] Seg5 = 7'b0100100;
  localparam logic [6:0] Seg6 = 7'b0100000;
  localparam logic [6:0] Seg7 = 7'b0001111;
  localparam logic [6:0] Seg8 = 7'b0000000;
  localparam logic [6:0] Seg9 = 7'b0000100;
  localparam logic [6:0] SegA = 7'b0001000;
  localparam logic [6:0] SegB = 7'b1100000;
  localparam logic [6:0] SegC = 7'b0110001;
  localparam logic [6:0] SegD = 7'b1000010;
  localparam logic [6:0] SegE = 7'b0110000;
  localparam logic [6:0] SegF = 7'b0111000;

  // Largest legal digit value for the selected radix.
  function automatic logic [3:0] digit_max(input logic hex_mode);
    return hex_mode ? 4'hF : 4'h9;
  endfunction

  // Non-decimal values in decimal mode decode to blank.
  function automatic logic [6:0] seg7_encode(input logic [3:0] value, input logic hex_mode);
    logic [6:0] seg;
    unique case (value)
      4'h0: seg = Seg0;
      4'h1: seg = Seg1;
      4'h2: seg = Seg2;
      4'h3: seg = Seg3;
      4'h4: seg = Seg4;
      4'h5: seg = Seg5;
      4'h6: seg = Seg6;
      4'h7: seg = Seg7;
      4'h8: seg = Seg8;
      4'h9: seg = Seg9;
      4'hA: seg = hex_mode ? SegA : SegBlank;
      4'hB: seg = hex_mode ? SegB : SegBlank;
      4'hC: seg = hex_mode ? SegC : SegBlank;
      4'hD: seg = hex_mode ? SegD : SegBlank;
      4'hE: seg = hex_mode ? SegE : SegBlank;
      default: seg = hex_mode ? SegF : SegBlank;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational single-digit 7-segment decoder (active-low outputs).
module seg7_digit
  import seg7_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       hex_mode_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = seg7_encode(value_i, hex_mode_i);
  end

endmodule

// File: rtl/bcd_hex_counter.sv
// Prescaled multi-digit up/down BCD or hex counter with registered
// 7-segment outputs and optional leading-zero blanking.
module bcd_hex_counter
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 50000000,
  parameter int unsigned HEX_MODE = 0
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  input  logic                  BLANK_LZ,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic                  CARRY,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int unsigned     PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PresLast = PW'(PRESCALE - 1);
  localparam logic            HexMode  = (HEX_MODE != 0);
  localparam logic [3:0]      DigitMax = digit_max(HexMode);

  logic [PW-1:0]         presc_q, presc_d;
  logic [4*DIGITS-1:0]   count_q, count_d;
  logic                  carry_q, carry_d;
  logic [7*DIGITS-1:0]   hex_q, hex_d;
  logic                  tick;
  logic [6:0]            seg [DIGITS];

  assign tick = (presc_q == PresLast);

  // A load restarts the prescaler so the next tick is a full period away.
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (LOAD || tick) begin
      presc_d = '0;
    end
  end

  always_comb begin
    logic       ripple;
    logic [3:0] dig;
    count_d = count_q;
    carry_d = 1'b0;
    ripple  = 1'b1;
    dig     = 4'h0;
    if (LOAD) begin
      for (int k = 0; k < DIGITS; k++) begin
        dig = LOAD_VAL[4*k +: 4];
        count_d[4*k +: 4] = (dig > DigitMax) ? 4'h0 : dig;
      end
    end else if (tick && EN) begin
      for (int k = 0; k < DIGITS; k++) begin
        dig = count_q[4*k +: 4];
        if (ripple) begin
          if (UP) begin
            if (dig == DigitMax) begin
              count_d[4*k +: 4] = 4'h0;
            end else begin
              count_d[4*k +: 4] = dig + 4'd1;
              ripple = 1'b0;
            end
          end else begin
            if (dig == 4'h0) begin
              count_d[4*k +: 4] = DigitMax;
            end else begin
              count_d[4*k +: 4] = dig - 4'd1;
              ripple = 1'b0;
            end
          end
        end
      end
      // Ripple surviving past the top digit means the whole counter wrapped.
      carry_d = ripple;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
    seg7_digit u_seg7_digit (
      .value_i    (count_q[4*g +: 4]),
      .hex_mode_i (HexMode),
      .seg_o      (seg[g])
    );
  end

  // Scan from the top digit; blanking stops at the first non-zero digit.
  always_comb begin
    logic lead_zero;
    lead_zero = BLANK_LZ;
    hex_d     = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (count_q[4*k +: 4] != 4'h0) begin
        lead_zero = 1'b0;
      end
      hex_d[7*k +: 7] = (lead_zero && (k != 0)) ? SegBlank : seg[k];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      hex_q   <= '1;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      carry_q <= carry_d;
      hex_q   <= hex_d;
    end
  end

  assign COUNT = count_q;
  assign CARRY = carry_q;
  assign HEX   = hex_q;

endmodule
